// File: rtl/pll_nco_clkgen_if.sv
// Control and output bundle of the multi-channel NCO clock generator.
// The bus master drives the rate/alignment controls; the generator drives the outputs.
interface pll_nco_clkgen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32
);
  logic                      enable;
  logic [NUM_CH*ACC_W-1:0]   inc;
  logic                      inc_load;
  logic                      sync_in;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         outclk;
  logic                      locked;
  logic                      load_pend;

  modport master (
    output enable, inc, inc_load, sync_in,
    input  tick, outclk, locked, load_pend
  );

  modport slave (
    input  enable, inc, inc_load, sync_in,
    output tick, outclk, locked, load_pend
  );
endinterface

// File: rtl/pll_nco_clkgen.sv
// Multi-channel NCO clock generator: per-channel phase accumulators produce wrap ticks
// and ~50% square waves, with shadowed rate loads, sync realignment and a lock qualifier.
module pll_nco_clkgen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_MODE   = 1
) (
  input logic            refclk,
  input logic            rst_n,
  pll_nco_clkgen_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    SETTLE,
    LOCKED
  } state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [NUM_CH-1:0][ACC_W-1:0]    acc;
  logic [NUM_CH-1:0][ACC_W-1:0]    act_inc;
  logic [NUM_CH-1:0][ACC_W-1:0]    shadow;
  logic [NUM_CH-1:0][ACC_W:0]      sum;
  logic [NUM_CH-1:0]               tick_q;
  logic [NUM_CH-1:0]               outclk_q;
  logic                            locked_q;
  logic                            load_pend_q;
  logic                            apply;
  logic                            running;

  // A pending load is applied either immediately (free-running) or on the alignment pulse.
  assign apply   = (SYNC_MODE != 0) ? (load_pend_q && bus.sync_in) : load_pend_q;
  assign running = (state != IDLE) && bus.enable && !bus.sync_in;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, act_inc[i]};
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nxt = (SYNC_MODE != 0) ? WAIT_SYNC : SETTLE;
          cnt_nxt   = '0;
        end
      end
      WAIT_SYNC: begin
        if (bus.sync_in) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (apply) begin
          cnt_nxt = '0;
        end else begin
          if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (apply) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping enable overrides everything and parks the generator.
    if (!bus.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      locked_q <= (state_nxt == LOCKED);
    end
  end

  // NOTE: the increment registers are reset too, so a reset really returns every channel to frozen.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      act_inc     <= '0;
      shadow      <= '0;
      tick_q      <= '0;
      outclk_q    <= '0;
      load_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (running) begin
          acc[i]      <= sum[i][ACC_W-1:0];
          tick_q[i]   <= sum[i][ACC_W];
          outclk_q[i] <= sum[i][ACC_W-1];
        end else begin
          acc[i]      <= '0;
          tick_q[i]   <= 1'b0;
          outclk_q[i] <= 1'b0;
        end
      end
      // Apply uses the shadow as it was before this edge; a simultaneous load stays pending.
      if (apply) act_inc <= shadow;
      if (bus.inc_load) shadow <= bus.inc;
      load_pend_q <= bus.inc_load | (load_pend_q & ~apply);
    end
  end

  assign bus.tick      = tick_q;
  assign bus.outclk    = outclk_q;
  assign bus.locked    = locked_q;
  assign bus.load_pend = load_pend_q;

endmodule
